// File: rtl/l2_tlb_attr_array.sv
// L2 TLB page-attribute store: per-set tree-PLRU victim choice, one-cycle set reads,
// and a set-walking flush that clears valid and PLRU state.
module l2_tlb_attr_array #(
    parameter int WAYS = 4,
    parameter int SETS = 16,
    localparam int IW = $clog2(SETS),
    localparam int WW = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lookup_valid,
    input  logic [IW-1:0]   lookup_idx,
    output logic            resp_valid,
    output logic [WAYS-1:0] resp_v,
    output logic [WAYS-1:0] resp_u,
    output logic [WAYS-1:0] resp_sw,
    output logic [WAYS-1:0] resp_d,
    output logic [WAYS-1:0] resp_w,
    output logic [WAYS-1:0] resp_r,
    output logic [WAYS-1:0] resp_x,
    input  logic            touch_valid,
    input  logic [IW-1:0]   touch_idx,
    input  logic [WW-1:0]   touch_way,
    input  logic            io_ptw_resp_valid,
    input  logic [IW-1:0]   refill_idx,
    input  logic            io_ptw_resp_bits_pte_v,
    input  logic            io_ptw_resp_bits_pte_u,
    input  logic            io_ptw_resp_bits_pte_w,
    input  logic            io_ptw_resp_bits_pte_x,
    input  logic            io_ptw_resp_bits_pte_r,
    input  logic            io_ptw_resp_bits_pte_d,
    input  logic            prot_w,
    output logic [WW-1:0]   refill_way,
    input  logic            flush_req,
    output logic            flush_ready,
    output logic            flush_done
);

    typedef enum logic {IDLE, FLUSH} state_e;

    typedef logic [SETS-1:0][WAYS-1:0] arr_t;
    typedef logic [SETS-1:0][WAYS-2:0] plru_arr_t;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            done_q, done_d;

    arr_t            v_q, u_q, sw_q, d_q, w_q, r_q, x_q;
    arr_t            v_d, u_d, sw_d, d_d, w_d, r_d, x_d;
    plru_arr_t       plru_q, plru_d;

    logic            rsp_vld_q;
    logic [WAYS-1:0] rv_q, ru_q, rsw_q, rd_q, rw_q, rr_q, rx_q;

    logic [WW-1:0]   victim;
    logic [WAYS-1:0] set_v;
    logic            refill_ok, touch_ok, flushing;

    // Heap-ordered tree: node n lives at bit n-1, children are 2n and 2n+1.
    function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] t);
        int n;
        n = 1;
        for (int l = 0; l < WW; l++) begin
            n = 2 * n + int'(t[n-1]);
        end
        return WW'(n - WAYS);
    endfunction

    function automatic logic [WAYS-2:0] plru_mru(input logic [WAYS-2:0] t,
                                                 input logic [WW-1:0]   way);
        logic [WAYS-2:0] res;
        logic            b;
        int              n;
        res = t;
        n   = 1;
        for (int l = 0; l < WW; l++) begin
            b        = way[WW-1-l];
            res[n-1] = ~b;
            n        = 2 * n + int'(b);
        end
        return res;
    endfunction

    always_comb begin
        set_v  = v_q[refill_idx];
        victim = plru_victim(plru_q[refill_idx]);
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!set_v[i]) victim = WW'(i);
        end
    end

    assign refill_way  = victim;
    assign flush_ready = (state_q == IDLE);
    assign flush_done  = done_q;
    assign flushing    = (state_q == FLUSH);
    assign refill_ok   = io_ptw_resp_valid && (state_q == IDLE);
    assign touch_ok    = touch_valid && !(flushing && ptr_q == touch_idx);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    ptr_d   = '0;
                end
            end
            FLUSH: begin
                if (ptr_q == IW'(SETS - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
        endcase
    end

    // Refill's PLRU update is applied on top of a same-set touch so it wins.
    always_comb begin
        v_d    = v_q;
        u_d    = u_q;
        sw_d   = sw_q;
        d_d    = d_q;
        w_d    = w_q;
        r_d    = r_q;
        x_d    = x_q;
        plru_d = plru_q;
        if (touch_ok) begin
            plru_d[touch_idx] = plru_mru(plru_d[touch_idx], touch_way);
        end
        if (refill_ok) begin
            v_d[refill_idx][victim]  = 1'b1;
            u_d[refill_idx][victim]  = io_ptw_resp_bits_pte_u;
            d_d[refill_idx][victim]  = io_ptw_resp_bits_pte_d;
            w_d[refill_idx][victim]  = io_ptw_resp_bits_pte_w;
            r_d[refill_idx][victim]  = io_ptw_resp_bits_pte_r;
            x_d[refill_idx][victim]  = io_ptw_resp_bits_pte_x;
            sw_d[refill_idx][victim] = io_ptw_resp_bits_pte_v
                                     & io_ptw_resp_bits_pte_r
                                     & io_ptw_resp_bits_pte_w
                                     & prot_w;
            plru_d[refill_idx] = plru_mru(plru_d[refill_idx], victim);
        end
        if (flushing) begin
            v_d[ptr_q]    = '0;
            plru_d[ptr_q] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            v_q     <= '0;
            u_q     <= '0;
            sw_q    <= '0;
            d_q     <= '0;
            w_q     <= '0;
            r_q     <= '0;
            x_q     <= '0;
            plru_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            v_q     <= v_d;
            u_q     <= u_d;
            sw_q    <= sw_d;
            d_q     <= d_d;
            w_q     <= w_d;
            r_q     <= r_d;
            x_q     <= x_d;
            plru_q  <= plru_d;
        end
    end

    // Read captures pre-update contents, so same-cycle writes stay invisible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_vld_q <= 1'b0;
            rv_q      <= '0;
            ru_q      <= '0;
            rsw_q     <= '0;
            rd_q      <= '0;
            rw_q      <= '0;
            rr_q      <= '0;
            rx_q      <= '0;
        end else begin
            rsp_vld_q <= lookup_valid;
            rv_q      <= lookup_valid ? v_q[lookup_idx]  : '0;
            ru_q      <= lookup_valid ? u_q[lookup_idx]  : '0;
            rsw_q     <= lookup_valid ? sw_q[lookup_idx] : '0;
            rd_q      <= lookup_valid ? d_q[lookup_idx]  : '0;
            rw_q      <= lookup_valid ? w_q[lookup_idx]  : '0;
            rr_q      <= lookup_valid ? r_q[lookup_idx]  : '0;
            rx_q      <= lookup_valid ? x_q[lookup_idx]  : '0;
        end
    end

    assign resp_valid = rsp_vld_q;
    assign resp_v     = rv_q;
    assign resp_u     = ru_q;
    assign resp_sw    = rsw_q;
    assign resp_d     = rd_q;
    assign resp_w     = rw_q;
    assign resp_r     = rr_q;
    assign resp_x     = rx_q;

endmodule

// File: tb/tb_l2_tlb_attr_array.sv
// Scoreboard bench for l2_tlb_attr_array (default 4 ways x 16 sets).
module tb_l2_tlb_attr_array;

    logic       clk = 1'b0;
    logic       reset;
    logic       lookup_valid;
    logic [3:0] lookup_idx;
    logic       resp_valid;
    logic [3:0] resp_v, resp_u, resp_sw, resp_d, resp_w, resp_r, resp_x;
    logic       touch_valid;
    logic [3:0] touch_idx;
    logic [1:0] touch_way;
    logic       io_ptw_resp_valid;
    logic [3:0] refill_idx;
    logic       pte_v, pte_u, pte_w, pte_x, pte_r, pte_d;
    logic       prot_w;
    logic [1:0] refill_way;
    logic       flush_req;
    logic       flush_ready;
    logic       flush_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sbq[$];

    always #5 clk = ~clk;

    l2_tlb_attr_array dut (
        .clk                    (clk),
        .reset                  (reset),
        .lookup_valid           (lookup_valid),
        .lookup_idx             (lookup_idx),
        .resp_valid             (resp_valid),
        .resp_v                 (resp_v),
        .resp_u                 (resp_u),
        .resp_sw                (resp_sw),
        .resp_d                 (resp_d),
        .resp_w                 (resp_w),
        .resp_r                 (resp_r),
        .resp_x                 (resp_x),
        .touch_valid            (touch_valid),
        .touch_idx              (touch_idx),
        .touch_way              (touch_way),
        .io_ptw_resp_valid      (io_ptw_resp_valid),
        .refill_idx             (refill_idx),
        .io_ptw_resp_bits_pte_v (pte_v),
        .io_ptw_resp_bits_pte_u (pte_u),
        .io_ptw_resp_bits_pte_w (pte_w),
        .io_ptw_resp_bits_pte_x (pte_x),
        .io_ptw_resp_bits_pte_r (pte_r),
        .io_ptw_resp_bits_pte_d (pte_d),
        .prot_w                 (prot_w),
        .refill_way             (refill_way),
        .flush_req              (flush_req),
        .flush_ready            (flush_ready),
        .flush_done             (flush_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [3:0] v, u, sw, d, w, r, x);
        return {4'h0, v, u, sw, d, w, r, x};
    endfunction

    task automatic clr();
        lookup_valid      = 1'b0;
        lookup_idx        = '0;
        touch_valid       = 1'b0;
        touch_idx         = '0;
        touch_way         = '0;
        io_ptw_resp_valid = 1'b0;
        refill_idx        = '0;
        {pte_v, pte_u, pte_w, pte_x, pte_r, pte_d} = '0;
        prot_w            = 1'b0;
        flush_req         = 1'b0;
    endtask

    // One clock; checks the response to whatever lookup was driven this cycle.
    task automatic cyc();
        logic        lk;
        logic [31:0] e;
        logic [31:0] o;
        lk = lookup_valid;
        @(posedge clk);
        #1;
        o = pk(resp_v, resp_u, resp_sw, resp_d, resp_w, resp_r, resp_x);
        chk("resp_valid", 32'(resp_valid), 32'(lk));
        if (lk) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_data", o, e);
            end
        end else begin
            chk("resp_idle_zero", o, 32'h0);
        end
    endtask

    task automatic refill(input logic [3:0] idx, input logic v, u, w, x, r, d, pw);
        io_ptw_resp_valid = 1'b1;
        refill_idx        = idx;
        pte_v = v; pte_u = u; pte_w = w; pte_x = x; pte_r = r; pte_d = d;
        prot_w = pw;
    endtask

    task automatic lookup(input logic [3:0] idx, input logic [31:0] exp);
        lookup_valid = 1'b1;
        lookup_idx   = idx;
        sbq.push_back(exp);
    endtask

    initial begin
        int pulses;
        logic [31:0] e;
        clr();
        reset = 1'b1;
        repeat (2) cyc();
        chk("rst_ready", 32'(flush_ready), 32'd1);
        chk("rst_done", 32'(flush_done), 32'd0);
        chk("rst_refill_way", 32'(refill_way), 32'd0);
        reset = 1'b0;

        lookup(4'd3, 32'h0);
        cyc();
        clr();
        cyc();

        for (int i = 0; i < 4; i++) begin
            refill(4'd5, 1, 1, 1, 0, 1, 1, 1);
            chk("fill_way", 32'(refill_way), 32'(i));
            cyc();
            clr();
        end
        lookup(4'd5, pk(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0));
        cyc();
        clr();

        refill_idx = 4'd5;
        #1 chk("plru_notouch", 32'(refill_way), 32'd0);
        touch_valid = 1'b1;
        touch_idx   = 4'd5;
        touch_way   = 2'd0;
        cyc();
        clr();
        refill_idx = 4'd5;
        #1 chk("plru_touch0", 32'(refill_way), 32'd2);
        refill(4'd5, 1, 0, 1, 0, 1, 1, 1);
        cyc();
        clr();
        lookup(4'd5, pk(4'hF, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0));
        cyc();
        clr();

        refill(4'd9, 1, 0, 1, 0, 1, 0, 0);
        lookup(4'd9, 32'h0);
        cyc();
        clr();
        lookup(4'd9, pk(4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0));
        cyc();
        clr();

        flush_req = 1'b1;
        cyc();
        clr();
        for (int c = 1; c <= 16; c++) begin
            chk("flush_busy_ready", 32'(flush_ready), 32'd0);
            chk("flush_busy_done", 32'(flush_done), 32'd0);
            if (c == 4) refill(4'd10, 1, 1, 1, 1, 1, 1, 1);
            cyc();
            clr();
        end
        chk("flush_end_ready", 32'(flush_ready), 32'd1);
        chk("flush_end_done", 32'(flush_done), 32'd1);
        cyc();
        chk("flush_done_pulse", 32'(flush_done), 32'd0);

        for (int s = 0; s < 16; s++) begin
            if (s == 5) e = pk(4'h0, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
            else if (s == 9) e = pk(4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0);
            else e = 32'h0;
            lookup(4'(s), e);
            cyc();
        end
        clr();
        refill_idx = 4'd5;
        #1 chk("post_flush_way", 32'(refill_way), 32'd0);
        cyc();
        clr();

        refill(4'd2, 1, 1, 1, 1, 1, 1, 1);
        cyc();
        clr();
        flush_req = 1'b1;
        cyc();
        clr();
        repeat (7) cyc();
        reset = 1'b1;
        cyc();
        chk("abort_ready", 32'(flush_ready), 32'd1);
        chk("abort_done", 32'(flush_done), 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (flush_done) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        for (int s = 0; s < 16; s++) begin
            lookup(4'(s), 32'h0);
            cyc();
        end
        clr();
        cyc();
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l2_tlb_attr_array.md
# l2_tlb_attr_array

Registered, parametrised L2 TLB attribute store. It holds SETS×WAYS entries of the page attribute bits (v, u, sw, d, w, r, x). It selects refill victims with a per-set tree pseudo-LRU and serves one-cycle-latency set reads to the L2 TLB lookup pipeline. It also runs a sequential set-walking flush on behalf of sfence/PTW invalidate. It sits between the PTW response path and the L2 TLB tag/hit logic, replacing the per-set combinational attribute-update logic.

## Interface
Parameters:
- WAYS, 4, ways per set; power of 2, ≥2
- SETS, 16, number of sets; power of 2, ≥2

Ports (IW = log2(SETS), WW = log2(WAYS)):
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- lookup_valid  in  1  read request for set lookup_idx
- lookup_idx  in  IW  set to read
- resp_valid  out  1  read data valid (one cycle after request)
- resp_v, resp_u, resp_sw, resp_d, resp_w, resp_r, resp_x  out  WAYS each  attribute bit per way of the read set
- touch_valid  in  1  hit notification; updates PLRU of touch_idx
- touch_idx  in  IW  set that hit
- touch_way  in  WW  way that hit
- io_ptw_resp_valid  in  1  refill request for set refill_idx
- refill_idx  in  IW  set to refill
- io_ptw_resp_bits_pte_v/u/w/x/r/d  in  1 each  PTE attributes
- prot_w  in  1  PMA write permission for the refilled page
- refill_way  out  WW  victim way for refill_idx (combinational)
- flush_req  in  1  start full invalidate
- flush_ready  out  1  high when IDLE
- flush_done  out  1  one-cycle pulse at flush completion

## Operation
- FSM states:
  - IDLE: refills and flush_req accepted.
  - FLUSH: flush_ptr walks sets 0..SETS-1, one set per cycle. Each visited set has its v bits and PLRU bits cleared; other attribute bits are kept.
- flush_req sampled in IDLE → FLUSH with flush_ptr=0. After clearing set SETS-1 → IDLE, and flush_done pulses high for exactly the first IDLE cycle. flush_req in FLUSH is ignored.
- Victim selection for refill_idx:
  - If the set has any way with v=0, the victim is the lowest-index invalid way.
  - Otherwise it is the tree-PLRU victim. Each node bit 0 → descend to the lower-index half, 1 → upper half.
- Refill (io_ptw_resp_valid in IDLE) writes the victim way of refill_idx:
  - v=1
  - u=pte_u, d=pte_d, w=pte_w, r=pte_r, x=pte_x
  - sw = pte_v & pte_r & pte_w & prot_w
  - The refilled way becomes MRU.
- Refill during FLUSH is dropped: no array or PLRU change.
- Touch (touch_valid, any state except when flush_ptr==touch_idx this cycle) makes touch_way MRU: every node on its path is set to point away from it.
- Touch and refill to the same set in the same cycle: the refill's MRU update wins.
- Read:
  - lookup_valid at cycle t → resp_valid and resp_* in cycle t+1, holding the set contents as of the end of cycle t. This is read-before-write: a same-cycle refill or flush of that set is not visible.
  - Reads are accepted in both states.
  - resp_* is zero whenever resp_valid=0.

## Timing
- Reset (asynchronous):
  - all array bits and PLRU bits = 0, state=IDLE, flush_ptr=0
  - resp_valid=0, resp_*=0, flush_done=0
  - flush_ready=1, refill_way=0
- Read latency is 1 cycle. Refill, touch and flush writes take effect at the clock edge ending their cycle.
- flush_req in cycle 0 → flush_ready=0 in cycles 1..SETS, with set k cleared at the end of cycle k+1 → flush_ready=1 and flush_done=1 in cycle SETS+1.
- Reset asserted mid-flush aborts immediately to the reset state; no flush_done pulse.
- refill_way is combinational from the current state and refill_idx; it is valid in any cycle.

## Test plan
- Reset, then lookup_idx=3 in cycle 0 → cycle 1: resp_valid=1, all resp_* = 4'h0; cycle 2: resp_valid=0.
- Four refills to set 5 with v=u=w=r=d=1, x=0, prot_w=1 → refill_way = 0, 1, 2, 3 in order; lookup then gives resp_v=resp_u=resp_sw=resp_w=resp_r=resp_d=4'hF and resp_x=4'h0.
- PLRU replacement in full set 5:
  - With no touch, refill_way=0.
  - After touch_way=0, refill_way=2.
  - A refill there with u=0 gives resp_u=4'b1011.
- Refill with prot_w=0 (pte v=r=w=1) → sw bit of that way = 0. Refill and lookup of the same set in the same cycle → response shows the old value, and the next lookup shows the new one.
- With set 5 full, flush_req in cycle 0:
  - flush_ready=0 in cycles 1–16; flush_done=1 only in cycle 17.
  - A refill in cycle 4 is dropped.
  - Afterwards every set reads resp_v=4'h0, and refill_way=0 for set 5.
- Reset asserted during FLUSH at flush_ptr=7 → next cycle: flush_ready=1, flush_done=0, all sets read zero, and no flush_done pulse follows.
